// File: rtl/drac_pkg.sv
// Shared types for the instruction-cache responder: address fields, line type and FSM states.
package drac_pkg;

  localparam int unsigned ICACHE_LINE_BYTES = 16;

  typedef logic [39:0]  addr_t;
  typedef logic [127:0] icache_line_t;
  typedef logic [11:0]  icache_idx_t;
  typedef logic [27:0]  icache_vpn_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    MISS_WAIT,
    REFILL_RESP
  } icache_resp_state_t;

endpackage

// File: rtl/icache_responder_array.sv
// Tag/data storage with one registered read port and one write port, plus valid bits
// that support a single-cycle flash clear.
module icache_responder_array
  import drac_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned TAG_W = 32
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             clear_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [TAG_W-1:0] rd_tag_o,
  output icache_line_t     rd_data_o,
  input  logic [IDX_W-1:0] vld_idx_i,
  output logic             vld_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  icache_line_t     wr_data_i
);

  logic [TAG_W-1:0] tag_mem  [LINES];
  icache_line_t     data_mem [LINES];
  logic [LINES-1:0] valid_reg;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_mem[wr_idx_i]  <= wr_tag_i;
      data_mem[wr_idx_i] <= wr_data_i;
    end
    rd_tag_o  <= tag_mem[rd_idx_i];
    rd_data_o <= data_mem[rd_idx_i];
  end

  // Clear beats a same-cycle install so a flushed line never reappears.
  for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        valid_reg[gi] <= 1'b0;
      end else if (clear_i) begin
        valid_reg[gi] <= 1'b0;
      end else if (wr_en_i && (wr_idx_i == IDX_W'(gi))) begin
        valid_reg[gi] <= 1'b1;
      end
    end
  end

  assign vld_o = valid_reg[vld_idx_i];

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped instruction-cache responder with single-beat refill and fetch fault check.
// Optional performance counters are built when ICACHE_RESPONDER_PMU_EN is defined.
module icache_responder
  import drac_pkg::*;
#(
  parameter int unsigned ICACHE_LINES = 16,
  parameter int unsigned XCPT_CHECK   = 1
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         icache_req_valid_i,
  input  icache_idx_t  icache_req_bits_idx_i,
  input  icache_vpn_t  icache_req_bits_vpn_i,
  input  logic         icache_req_kill_i,
  input  logic         icache_invalidate_i,
  output logic         icache_req_ready_o,
  output logic         icache_resp_valid_o,
  output icache_line_t icache_resp_datablock_o,
  output addr_t        icache_resp_vaddr_o,
  output logic         tlb_resp_xcp_if_o,
  output logic         mem_req_valid_o,
  input  logic         mem_req_ready_i,
  output addr_t        mem_req_addr_o,
  input  logic         mem_resp_valid_i,
  input  icache_line_t mem_resp_data_i
`ifdef ICACHE_RESPONDER_PMU_EN
  ,
  output logic         pmu_hit_o,
  output logic         pmu_miss_o,
  output logic [31:0]  pmu_miss_cnt_o
`endif
);

  localparam int unsigned OFF_W  = $clog2(ICACHE_LINE_BYTES);
  localparam int unsigned IDX_W  = $clog2(ICACHE_LINES);
  localparam int unsigned LINE_W = 40 - OFF_W;
  localparam int unsigned TAG_W  = LINE_W - IDX_W;

  icache_resp_state_t state_reg, state_next;
  logic [LINE_W-1:0]  line_reg;
  logic               kill_reg;
  logic               inval_reg;
  icache_line_t       refill_data_reg;

  logic [LINE_W-1:0]  req_line;
  logic [IDX_W-1:0]   lookup_idx, rd_idx;
  logic [TAG_W-1:0]   lookup_tag, rd_tag;
  icache_line_t       rd_data;
  logic               rd_valid, fault, hit, killed, accept, req_ready, install;
  addr_t              line_addr;
  logic               unused_offset;

  assign req_line      = {icache_req_bits_vpn_i, icache_req_bits_idx_i[11:OFF_W]};
  assign unused_offset = ^icache_req_bits_idx_i[OFF_W-1:0];
  assign lookup_idx    = line_reg[IDX_W-1:0];
  assign lookup_tag    = line_reg[LINE_W-1 -: TAG_W];
  assign line_addr     = {line_reg, {OFF_W{1'b0}}};

  // Read address is steered to the incoming request so its line is ready in LOOKUP.
  assign rd_idx    = accept ? req_line[IDX_W-1:0] : lookup_idx;
  assign fault     = (XCPT_CHECK != 0) && (line_reg[LINE_W-1] != line_reg[LINE_W-2]);
  assign hit       = !fault && rd_valid && (rd_tag == lookup_tag);
  assign killed    = kill_reg || icache_req_kill_i;
  assign req_ready = (state_reg == IDLE) || ((state_reg == LOOKUP) && (hit || fault));
  assign accept    = icache_req_valid_i && req_ready;
  assign install   = (state_reg == MISS_WAIT) && mem_resp_valid_i && !inval_reg && !icache_invalidate_i;

  icache_responder_array #(
    .LINES (ICACHE_LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .clear_i   (icache_invalidate_i),
    .rd_idx_i  (rd_idx),
    .rd_tag_o  (rd_tag),
    .rd_data_o (rd_data),
    .vld_idx_i (lookup_idx),
    .vld_o     (rd_valid),
    .wr_en_i   (install),
    .wr_idx_i  (lookup_idx),
    .wr_tag_i  (lookup_tag),
    .wr_data_i (mem_resp_data_i)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:        if (accept) state_next = LOOKUP;
      LOOKUP:      state_next = (hit || fault) ? (accept ? LOOKUP : IDLE) : MISS_REQ;
      MISS_REQ:    if (mem_req_ready_i) state_next = MISS_WAIT;
      MISS_WAIT:   if (mem_resp_valid_i) state_next = REFILL_RESP;
      REFILL_RESP: state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  always_comb begin
    icache_req_ready_o      = req_ready;
    icache_resp_valid_o     = 1'b0;
    icache_resp_datablock_o = '0;
    icache_resp_vaddr_o     = '0;
    tlb_resp_xcp_if_o       = 1'b0;
    mem_req_valid_o         = 1'b0;
    mem_req_addr_o          = '0;
    case (state_reg)
      LOOKUP: begin
        if (hit && !killed) begin
          icache_resp_valid_o     = 1'b1;
          icache_resp_datablock_o = rd_data;
          icache_resp_vaddr_o     = line_addr;
        end
        tlb_resp_xcp_if_o = fault && !killed;
      end
      MISS_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = line_addr;
      end
      REFILL_RESP: begin
        if (!killed) begin
          icache_resp_valid_o     = 1'b1;
          icache_resp_datablock_o = refill_data_reg;
          icache_resp_vaddr_o     = line_addr;
        end
      end
      default: ;
    endcase
  end

  // Kill/invalidate history belongs to the current request and restarts on acceptance.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      line_reg        <= '0;
      kill_reg        <= 1'b0;
      inval_reg       <= 1'b0;
      refill_data_reg <= '0;
    end else begin
      if (accept) begin
        line_reg  <= req_line;
        kill_reg  <= icache_req_kill_i;
        inval_reg <= 1'b0;
      end else begin
        kill_reg  <= kill_reg || icache_req_kill_i;
        inval_reg <= inval_reg || (icache_invalidate_i &&
                     ((state_reg == LOOKUP) || (state_reg == MISS_REQ) || (state_reg == MISS_WAIT)));
      end
      if ((state_reg == MISS_WAIT) && mem_resp_valid_i) begin
        refill_data_reg <= mem_resp_data_i;
      end
    end
  end

`ifdef ICACHE_RESPONDER_PMU_EN
  logic [31:0] miss_cnt_reg;

  assign pmu_hit_o      = (state_reg == LOOKUP) && hit;
  assign pmu_miss_o     = (state_reg == LOOKUP) && !hit && !fault;
  assign pmu_miss_cnt_o = miss_cnt_reg;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      miss_cnt_reg <= '0;
    end else if (pmu_miss_o && (miss_cnt_reg != '1)) begin
      miss_cnt_reg <= miss_cnt_reg + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Bench for icache_responder: directed scenarios then random traffic against a line-level cache model.
module tb_icache_responder;

  logic         clk_i = 1'b0;
  logic         rstn_i = 1'b0;
  logic         icache_req_valid_i = 1'b0;
  logic [11:0]  icache_req_bits_idx_i = '0;
  logic [27:0]  icache_req_bits_vpn_i = '0;
  logic         icache_req_kill_i = 1'b0;
  logic         icache_invalidate_i = 1'b0;
  logic         icache_req_ready_o;
  logic         icache_resp_valid_o;
  logic [127:0] icache_resp_datablock_o;
  logic [39:0]  icache_resp_vaddr_o;
  logic         tlb_resp_xcp_if_o;
  logic         mem_req_valid_o;
  logic         mem_req_ready_i = 1'b0;
  logic [39:0]  mem_req_addr_o;
  logic         mem_resp_valid_i = 1'b0;
  logic [127:0] mem_resp_data_i = '0;

  int checks = 0;
  int failures = 0;

  bit           m_valid [16];
  logic [31:0]  m_tag   [16];
  logic [127:0] m_data  [16];
  logic [31:0]  tag_pool [5];

  icache_responder #(.ICACHE_LINES(16), .XCPT_CHECK(1)) dut (
    .clk_i                   (clk_i),
    .rstn_i                  (rstn_i),
    .icache_req_valid_i      (icache_req_valid_i),
    .icache_req_bits_idx_i   (icache_req_bits_idx_i),
    .icache_req_bits_vpn_i   (icache_req_bits_vpn_i),
    .icache_req_kill_i       (icache_req_kill_i),
    .icache_invalidate_i     (icache_invalidate_i),
    .icache_req_ready_o      (icache_req_ready_o),
    .icache_resp_valid_o     (icache_resp_valid_o),
    .icache_resp_datablock_o (icache_resp_datablock_o),
    .icache_resp_vaddr_o     (icache_resp_vaddr_o),
    .tlb_resp_xcp_if_o       (tlb_resp_xcp_if_o),
    .mem_req_valid_o         (mem_req_valid_o),
    .mem_req_ready_i         (mem_req_ready_i),
    .mem_req_addr_o          (mem_req_addr_o),
    .mem_resp_valid_i        (mem_resp_valid_i),
    .mem_resp_data_i         (mem_resp_data_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},    icache_req_ready_o, 1);
    check({tag, "_rvalid"},   icache_resp_valid_o, 0);
    check({tag, "_rdata"},    icache_resp_datablock_o, 0);
    check({tag, "_rvaddr"},   icache_resp_vaddr_o, 0);
    check({tag, "_xcp"},      tlb_resp_xcp_if_o, 0);
    check({tag, "_mvalid"},   mem_req_valid_o, 0);
    check({tag, "_maddr"},    mem_req_addr_o, 0);
  endtask

  task automatic model_flush();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  task automatic drive_req(input logic [39:0] a, input bit kill);
    icache_req_valid_i    = 1'b1;
    icache_req_bits_idx_i = a[11:0];
    icache_req_bits_vpn_i = a[39:12];
    icache_req_kill_i     = kill;
  endtask

  // One full transaction from an idle cache; the model decides fault, hit or miss.
  task automatic run_req(input logic [39:0] a, input bit kill_acc, input bit kill_wait,
                         input bit inval_wait, input logic [127:0] fill);
    int          idx;
    int          wc;
    logic [31:0] tg;
    logic [39:0] line_a;
    bit          fault, hit, killed;
    string       kind;
    idx    = int'(a[7:4]);
    tg     = a[39:8];
    line_a = {a[39:4], 4'h0};
    fault  = a[39] ^ a[38];
    hit    = !fault && m_valid[idx] && (m_tag[idx] == tg);
    killed = kill_acc;
    kind   = fault ? "fault" : (hit ? "hit" : "miss");
    @(negedge clk_i);
    check("idle_ready", icache_req_ready_o, 1);
    drive_req(a, kill_acc);
    @(negedge clk_i);
    if (fault) begin
      check("fault_xcp", tlb_resp_xcp_if_o, !kill_acc);
      check("fault_rvalid", icache_resp_valid_o, 0);
      check("fault_rdata", icache_resp_datablock_o, 0);
      check("fault_mreq", mem_req_valid_o, 0);
      check("fault_ready", icache_req_ready_o, 1);
    end else if (hit) begin
      check("hit_rvalid", icache_resp_valid_o, !kill_acc);
      check("hit_rdata", icache_resp_datablock_o, kill_acc ? 128'h0 : m_data[idx]);
      check("hit_rvaddr", icache_resp_vaddr_o, kill_acc ? 40'h0 : line_a);
      check("hit_ready", icache_req_ready_o, 1);
      check("hit_mreq", mem_req_valid_o, 0);
    end else begin
      check("miss_rvalid", icache_resp_valid_o, 0);
      check("miss_ready", icache_req_ready_o, 0);
    end
    icache_req_valid_i = 1'b0;
    icache_req_kill_i  = 1'b0;
    if (!fault && !hit) begin
      @(negedge clk_i);
      check("mreq_valid", mem_req_valid_o, 1);
      check("mreq_addr", mem_req_addr_o, line_a);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk_i);
        check("mreq_hold_valid", mem_req_valid_o, 1);
        check("mreq_hold_addr", mem_req_addr_o, line_a);
      end
      mem_req_ready_i = 1'b1;
      @(negedge clk_i);
      mem_req_ready_i = 1'b0;
      check("mreq_drop", mem_req_valid_o, 0);
      icache_req_kill_i   = kill_wait;
      icache_invalidate_i = inval_wait;
      if (inval_wait) model_flush();
      killed = kill_acc || kill_wait;
      wc = int'($urandom_range(0, 3));
      repeat (wc) begin
        @(negedge clk_i);
        icache_req_kill_i   = 1'b0;
        icache_invalidate_i = 1'b0;
        check("wait_rvalid", icache_resp_valid_o, 0);
      end
      mem_resp_valid_i = 1'b1;
      mem_resp_data_i  = fill;
      @(negedge clk_i);
      icache_req_kill_i   = 1'b0;
      icache_invalidate_i = 1'b0;
      mem_resp_valid_i    = 1'b0;
      mem_resp_data_i     = '0;
      check("refill_rvalid", icache_resp_valid_o, !killed);
      check("refill_rdata", icache_resp_datablock_o, killed ? 128'h0 : fill);
      check("refill_rvaddr", icache_resp_vaddr_o, killed ? 40'h0 : line_a);
      if (!inval_wait) begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        m_data[idx]  = fill;
      end
    end
    @(negedge clk_i);
    check("after_rvalid", icache_resp_valid_o, 0);
    check("after_xcp", tlb_resp_xcp_if_o, 0);
    check("after_ready", icache_req_ready_o, 1);
    $display("txn %s addr=%h kill=%0d/%0d inval=%0d", kind, a, kill_acc, kill_wait, inval_wait);
  endtask

  initial begin
    logic [39:0]  a;
    logic [127:0] d;
    tag_pool[0] = 32'h0000_0001;
    tag_pool[1] = 32'h0000_0002;
    tag_pool[2] = 32'h0001_2345;
    tag_pool[3] = 32'h8000_0000;
    tag_pool[4] = 32'h4000_0001;
    model_flush();

    #1;
    check_reset_outputs("reset");
    @(negedge clk_i);
    @(negedge clk_i);
    rstn_i = 1'b1;

    run_req(40'h00_0000_1040, 0, 0, 0, {16{8'hA5}});
    run_req(40'h00_0000_1048, 0, 0, 0, '0);
    run_req(40'h80_0000_0000, 0, 0, 0, '0);
    run_req(40'h00_0000_2050, 0, 1, 0, {4{32'h1234_5678}});
    run_req(40'h00_0000_2058, 0, 0, 0, '0);
    run_req(40'h00_0000_1044, 1, 0, 0, '0);

    // Back-to-back hits: the second request is accepted in the first one's LOOKUP cycle.
    @(negedge clk_i);
    drive_req(40'h00_0000_1040, 0);
    @(negedge clk_i);
    check("b2b_a_rvalid", icache_resp_valid_o, 1);
    check("b2b_a_rdata", icache_resp_datablock_o, m_data[4]);
    check("b2b_a_ready", icache_req_ready_o, 1);
    drive_req(40'h00_0000_205c, 0);
    @(negedge clk_i);
    icache_req_valid_i = 1'b0;
    check("b2b_b_rvalid", icache_resp_valid_o, 1);
    check("b2b_b_rdata", icache_resp_datablock_o, m_data[5]);
    check("b2b_b_rvaddr", icache_resp_vaddr_o, 40'h00_0000_2050);
    @(negedge clk_i);
    check("b2b_idle_rvalid", icache_resp_valid_o, 0);
    $display("txn b2b addr=%h,%h", 40'h00_0000_1040, 40'h00_0000_205c);

    run_req(40'h00_0000_3060, 0, 0, 1, {4{32'hCAFE_F00D}});
    run_req(40'h00_0000_3064, 0, 0, 0, {4{32'h0BAD_BEEF}});

    // Reset while the refill request is pending, then a stray memory beat in IDLE.
    @(negedge clk_i);
    drive_req(40'h00_0000_4070, 0);
    @(negedge clk_i);
    icache_req_valid_i = 1'b0;
    @(negedge clk_i);
    check("prereset_mreq", mem_req_valid_o, 1);
    rstn_i = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_flush();
    @(negedge clk_i);
    rstn_i           = 1'b1;
    mem_resp_valid_i = 1'b1;
    mem_resp_data_i  = {4{32'hDEAD_0000}};
    @(negedge clk_i);
    mem_resp_valid_i = 1'b0;
    mem_resp_data_i  = '0;
    check("stray_rvalid", icache_resp_valid_o, 0);
    check("stray_ready", icache_req_ready_o, 1);
    $display("txn reset_mid_refill addr=%h", 40'h00_0000_4070);
    run_req(40'h00_0000_4070, 0, 0, 0, {4{32'h7777_1111}});

    for (int n = 0; n < 80; n++) begin
      a = {tag_pool[$urandom_range(0, 4)], 4'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
      d = {$urandom, $urandom, $urandom, $urandom};
      run_req(a, ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 7) == 0), d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit reached");
  end

endmodule

// File: doc/icache_responder.md
ICACHE_RESPONDER -- requirements
Module: icache_responder

Interface
REQ-001 SHALL have parameter ICACHE_LINES, default 16, direct-mapped line count (power of two, 2..256).
REQ-002 SHALL have parameter XCPT_CHECK, default 1, enables the bit-39/bit-38 address fault check.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rstn_i  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port icache_req_valid_i  input  1  fetch request valid.
REQ-006 SHALL have port icache_req_bits_idx_i  input  12  vaddr[11:0].
REQ-007 SHALL have port icache_req_bits_vpn_i  input  28  vaddr[39:12].
REQ-008 SHALL have port icache_req_kill_i  input  1  cancel the outstanding request.
REQ-009 SHALL have port icache_invalidate_i  input  1  flush all lines.
REQ-010 SHALL have port icache_req_ready_o  output  1  request accepted when valid and ready are both high.
REQ-011 SHALL have port icache_resp_valid_o  output  1  response pulse.
REQ-012 SHALL have port icache_resp_datablock_o  output  128  16-byte line.
REQ-013 SHALL have port icache_resp_vaddr_o  output  40  request address, line-aligned.
REQ-014 SHALL have port tlb_resp_xcp_if_o  output  1  fetch page-fault pulse.
REQ-015 SHALL have port mem_req_valid_o / mem_req_ready_i  output / input  1 / 1  refill request handshake.
REQ-016 SHALL have port mem_req_addr_o  output  40  line-aligned refill address.
REQ-017 SHALL have port mem_resp_valid_i / mem_resp_data_i  input / input  1 / 128  refill data, one beat.

Function
REQ-018 SHALL use these address fields: index = vaddr[4+log2(ICACHE_LINES)-1:4]; tag = the remaining upper bits; vaddr equals paddr (no translation).
REQ-019 SHALL use FSM states IDLE, LOOKUP, MISS_REQ, MISS_WAIT, REFILL_RESP.
REQ-020 SHALL assert icache_req_ready_o in IDLE, and in LOOKUP on a hit or fault; it SHALL be low in all other states.
REQ-021 SHALL, on acceptance, register the address and go to LOOKUP.
REQ-022 SHALL, in LOOKUP on a hit, pulse icache_resp_valid_o with the line, one cycle after acceptance.
REQ-023 SHALL, in LOOKUP on a fault (XCPT_CHECK and vaddr[39]!=vaddr[38]), pulse tlb_resp_xcp_if_o, drive icache_resp_valid_o low and the datablock to 0, and issue no memory request.
REQ-024 SHALL, in LOOKUP on a miss, go to MISS_REQ.
REQ-025 SHALL hold mem_req_valid_o high in MISS_REQ until mem_req_ready_i, then go to MISS_WAIT; mem_req_addr_o SHALL stay stable while valid is high.
REQ-026 SHALL, in MISS_WAIT on mem_resp_valid_i, write the tag, data and valid bit and go to REFILL_RESP.
REQ-027 SHALL, in REFILL_RESP, pulse the response with the refilled line, then go to IDLE.
REQ-028 SHALL treat kill (any cycle while a request is outstanding, including the accept cycle) as suppressing that request's response and fault pulse; an in-flight refill still completes and installs.
REQ-029 SHALL clear all valid bits at the next edge on invalidate; a refill in flight during or after the invalidate SHALL return its data but not install.
REQ-030 SHALL give invalidate priority when invalidate and a same-cycle install coincide: the line ends invalid.
REQ-031 SHALL treat a LOOKUP hit plus a new acceptance in the same cycle as back-to-back operation: the next lookup follows with no bubble.
REQ-032 SHALL have response outputs that are zero whenever the response valid is low.

Reset
REQ-033 SHALL, on reset, set state IDLE, all valid bits 0, all outputs 0 except icache_req_ready_o=1, and the kill and invalidate flags 0.
REQ-034 SHALL, on reset mid-refill, abandon the transaction; a later mem_resp_valid_i arriving in IDLE SHALL be ignored.

Configuration
REQ-035 SHALL, with ICACHE_RESPONDER_PMU_EN defined, add outputs pmu_hit_o and pmu_miss_o (1-cycle pulses on a LOOKUP hit/miss, killed requests included) and a 32-bit saturating miss counter pmu_miss_cnt_o that resets to 0.
REQ-036 SHALL, without ICACHE_RESPONDER_PMU_EN, omit these ports and the counter logic entirely.

Structure
REQ-037 SHALL place the icache_resp_state_t enum and ICACHE_LINE_BYTES=16 in drac_pkg; icache_line_t, addr_t, icache_idx_t and icache_vpn_t SHALL be reused from drac_pkg.
REQ-038 SHALL instantiate one sub-module, icache_responder_array, containing the tag/data/valid storage with 1 read port, 1 write port and a flash-clear.

Verification
REQ-039 SHALL cover a cold miss: req 0x0000001040 -> mem_req_addr_o=0x0000001040; data 0xA5.. -> resp 1 cycle after mem_resp_valid_i, vaddr 0x0000001040.
REQ-040 SHALL cover a hit: repeat req 0x0000001048 -> resp_valid 1 cycle later with the same line; no mem request.
REQ-041 SHALL cover a fault: req 0x8000000000 -> tlb_resp_xcp_if_o=1 for 1 cycle, resp_valid=0, datablock 0.
REQ-042 SHALL cover kill during MISS_WAIT: no response pulse; a following req to the same line hits.
REQ-043 SHALL cover invalidate during MISS_WAIT: the response is returned; the next req to the same line misses.
REQ-044 SHALL cover reset asserted in MISS_REQ: outputs return to reset values immediately; the bench SHALL check all outputs.
